// File: rtl/issue_dispatch.sv
// Issue front end: buffers fetched instruction words, decodes them and issues
// one at a time to the reservation stations, retrying with backoff on full.
module issue_dispatch #(
   parameter int FIFO_DEPTH = 4,
   parameter int REG_W      = 6,
   parameter int WORD_W     = 32,
   parameter int BACKOFF    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid,
   input  logic [31:0]       fetch_instr,
   output logic              fetch_ready,
   output logic [2:0]        unit,
   output logic [REG_W-1:0]  reg1,
   output logic [REG_W-1:0]  reg2,
   output logic [REG_W-1:0]  reg3,
   output logic              hasimm,
   output logic [WORD_W-1:0] imm,
   output logic              enable,
   input  logic              rs_ack,
   input  logic              rs_accept,
   output logic              halted,
   output logic [15:0]       issued_cnt,
   output logic [15:0]       stall_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_HALTED} state_t;
   state_t r_state, w_next;

   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [AW:0]       r_count;
   logic [BW-1:0]     r_boff;
   logic [2:0]        r_unit;
   logic [REG_W-1:0]  r_reg1, r_reg2, r_reg3;
   logic              r_hasimm;
   logic [WORD_W-1:0] r_imm;
   logic [15:0]       r_issued, r_stall;

   logic [31:0] w_head;
   logic        w_empty, w_full, w_legal, w_push, w_pop, w_load;
   logic        w_accept, w_reject, w_enable, w_halted;

   assign w_head      = r_mem[r_rptr];
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_legal     = (w_head[31:30] != 2'b11);
   assign fetch_ready = !w_full && !w_halted;
   assign w_push      = fetch_valid && fetch_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (!w_empty && w_legal) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT: begin
            if (rs_ack && rs_accept)
               w_next = (r_unit == 3'b101) ? S_HALTED : S_IDLE;
            else if (rs_ack)
               w_next = (BACKOFF == 0) ? S_ISSUE : S_BACKOFF;
         end
         // counter holds the idle cycles still owed, so leave on its last one
         S_BACKOFF: if (r_boff <= BW'(1)) w_next = S_ISSUE;
         S_HALTED:  w_next = S_HALTED;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_enable = (r_state == S_ISSUE);
      w_halted = (r_state == S_HALTED);
      w_load   = (r_state == S_IDLE) && !w_empty && w_legal;
      w_accept = (r_state == S_WAIT) && rs_ack && rs_accept;
      w_reject = (r_state == S_WAIT) && rs_ack && !rs_accept;
      w_pop    = ((r_state == S_IDLE) && !w_empty && !w_legal) || w_accept;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= fetch_instr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_halted) begin
         r_rptr  <= r_wptr;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_unit   <= '0;
         r_reg1   <= '0;
         r_reg2   <= '0;
         r_reg3   <= '0;
         r_hasimm <= 1'b0;
         r_imm    <= '0;
      end else if (w_load) begin
         r_unit   <= w_head[31:29];
         r_hasimm <= w_head[28];
         r_reg1   <= REG_W'(w_head[27:22]);
         r_reg2   <= REG_W'(w_head[21:16]);
         r_reg3   <= REG_W'(w_head[15:10]);
         r_imm    <= WORD_W'($signed(w_head[15:0]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issued <= '0;
         r_stall  <= '0;
         r_boff   <= '0;
      end else begin
         if (w_accept) r_issued <= r_issued + 1'b1;
         if (w_reject) begin
            r_stall <= r_stall + 1'b1;
            r_boff  <= BW'(BACKOFF);
         end else if (r_state == S_BACKOFF) begin
            r_boff  <= r_boff - 1'b1;
         end
      end
   end

   assign unit       = r_unit;
   assign reg1       = r_reg1;
   assign reg2       = r_reg2;
   assign reg3       = r_reg3;
   assign hasimm     = r_hasimm;
   assign imm        = r_imm;
   assign enable     = w_enable;
   assign halted     = w_halted;
   assign issued_cnt = r_issued;
   assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: decode vector table, hand-built corner sequences
// and a randomized run scored against a queue-based in-order issue model.
module tb_issue_dispatch;

   localparam int BACKOFF = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic        fetch_ready;
   logic [2:0]  unit;
   logic [5:0]  reg1, reg2, reg3;
   logic        hasimm;
   logic [31:0] imm;
   logic        enable;
   logic        rs_ack, rs_accept;
   logic        halted;
   logic [15:0] issued_cnt, stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   issue_dispatch #(
      .FIFO_DEPTH(4),
      .REG_W(6),
      .WORD_W(32),
      .BACKOFF(BACKOFF)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
      .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3),
      .hasimm(hasimm), .imm(imm), .enable(enable),
      .rs_ack(rs_ack), .rs_accept(rs_accept),
      .halted(halted), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [31:0] word;
      logic [2:0]  u;
      logic [5:0]  r1, r2, r3;
      logic        h;
      logic [31:0] im;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [53:0] dut_fields();
      return {unit, reg1, reg2, reg3, hasimm, imm};
   endfunction

   function automatic logic [53:0] exp_fields(input logic [31:0] w);
      return {w[31:29], w[27:22], w[21:16], w[15:10], w[28], {{16{w[15]}}, w[15:0]}};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      fetch_valid = 1'b0;
      fetch_instr = '0;
      rs_ack = 1'b0;
      rs_accept = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic push_word(input logic [31:0] w);
      int n = 0;
      fetch_valid = 1'b1;
      fetch_instr = w;
      while (!fetch_ready && n < 50) begin
         tick();
         n++;
      end
      if (!fetch_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_timeout: fetch_ready still %b after %0d cycles", fetch_ready, n);
      end
      tick();
      fetch_valid = 1'b0;
   endtask

   task automatic wait_enable(input string name);
      int n = 0;
      while (enable !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (enable !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: enable not seen within %0d cycles (got %b expected 1)", name, n, enable);
      end
   endtask

   // From the ISSUE cycle: step into WAIT, give one reply, step past it.
   task automatic reply(input logic acc);
      tick();
      rs_ack = 1'b1;
      rs_accept = acc;
      tick();
      rs_ack = 1'b0;
      rs_accept = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [6];
      logic [53:0] f0;
      logic [31:0] q [$];
      logic [31:0] prev_word, rw;
      logic        prev_xfer, awaiting, retry, acc;
      int          delay, rej_cyc, exp_iss, exp_stall, seen, n;
      logic [2:0]  ru;

      tbl[0] = '{{3'd2, 1'b0, 6'd5,  6'd6,  16'h1C00}, 3'd2, 6'd5,  6'd6,  6'd7,  1'b0, 32'h00001C00};
      tbl[1] = '{{3'd0, 1'b1, 6'd1,  6'd2,  16'hFFF0}, 3'd0, 6'd1,  6'd2,  6'd63, 1'b1, 32'hFFFFFFF0};
      tbl[2] = '{{3'd1, 1'b1, 6'd63, 6'd0,  16'h7FFF}, 3'd1, 6'd63, 6'd0,  6'd31, 1'b1, 32'h00007FFF};
      tbl[3] = '{{3'd3, 1'b0, 6'd10, 6'd20, 16'h7800}, 3'd3, 6'd10, 6'd20, 6'd30, 1'b0, 32'h00007800};
      tbl[4] = '{{3'd4, 1'b1, 6'd33, 6'd0,  16'h8000}, 3'd4, 6'd33, 6'd0,  6'd32, 1'b1, 32'hFFFF8000};
      tbl[5] = '{{3'd2, 1'b0, 6'd0,  6'd63, 16'h0400}, 3'd2, 6'd0,  6'd63, 6'd1,  1'b0, 32'h00000400};

      do_reset();
      chk("rst_enable", 64'(enable), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_ready", 64'(fetch_ready), 64'd1);
      chk("rst_fields", 64'(dut_fields()), 64'd0);
      chk("rst_counts", 64'({issued_cnt, stall_cnt}), 64'd0);

      // decode table: each entry issued and accepted one cycle after enable
      for (int i = 0; i < 6; i++) begin
         push_word(tbl[i].word);
         wait_enable("tbl_enable");
         chk($sformatf("tbl%0d_fields", i), 64'(dut_fields()),
             64'({tbl[i].u, tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].h, tbl[i].im}));
         tick();
         chk($sformatf("tbl%0d_pulse", i), 64'(enable), 64'd0);
         rs_ack = 1'b1;
         rs_accept = 1'b1;
         tick();
         rs_ack = 1'b0;
         rs_accept = 1'b0;
         chk($sformatf("tbl%0d_issued", i), 64'(issued_cnt), 64'(i + 1));
      end

      // full twice, then accept: retries land BACKOFF+1 cycles after each reply
      do_reset();
      push_word(tbl[0].word);
      wait_enable("bo_enable");
      f0 = dut_fields();
      for (int k = 0; k < 3; k++) begin
         reply(k == 2);
         if (k < 2) begin
            n = 1;
            while (enable !== 1'b1 && n < 20) begin
               tick();
               n++;
            end
            chk($sformatf("bo_gap%0d", k), 64'(n), 64'(BACKOFF + 1));
            chk($sformatf("bo_fields%0d", k), 64'(dut_fields()), 64'(f0));
         end
      end
      chk("bo_stall", 64'(stall_cnt), 64'd2);
      chk("bo_issued", 64'(issued_cnt), 64'd1);

      // five words with no reply: four fit, fifth waits for the first pop
      do_reset();
      for (int i = 0; i < 4; i++)
         push_word({3'd2, 1'b0, 6'(i + 1), 6'd0, 16'h0});
      chk("full_ready", 64'(fetch_ready), 64'd0);
      fetch_valid = 1'b1;
      fetch_instr = {3'd2, 1'b0, 6'd5, 6'd0, 16'h0};
      seen = 0;
      repeat (3) begin
         tick();
         if (fetch_ready) seen++;
      end
      chk("full_held", 64'(seen), 64'd0);
      rs_ack = 1'b1;
      rs_accept = 1'b1;
      tick();
      rs_ack = 1'b0;
      chk("full_reopen", 64'(fetch_ready), 64'd1);
      tick();
      fetch_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         wait_enable("full_enable");
         chk($sformatf("full_order%0d", i), 64'(reg1), 64'(i + 1));
         reply(1'b1);
      end
      chk("full_issued", 64'(issued_cnt), 64'd5);

      // illegal opcode is dropped silently
      do_reset();
      push_word({3'b111, 1'b0, 6'd9, 6'd9, 16'h2400});
      push_word(tbl[3].word);
      wait_enable("ill_enable");
      chk("ill_unit", 64'(unit), 64'd3);
      reply(1'b1);
      seen = 0;
      repeat (10) begin
         tick();
         if (enable) seen++;
      end
      chk("ill_extra", 64'(seen), 64'd0);
      chk("ill_issued", 64'(issued_cnt), 64'd1);

      // halt stops dispatch and discards the following add
      do_reset();
      push_word({3'd5, 1'b0, 6'd0, 6'd0, 16'h0});
      push_word(tbl[0].word);
      wait_enable("halt_enable");
      chk("halt_unit", 64'(unit), 64'd5);
      reply(1'b1);
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_ready", 64'(fetch_ready), 64'd0);
      seen = 0;
      repeat (10) begin
         tick();
         if (enable) seen++;
      end
      chk("halt_extra", 64'(seen), 64'd0);
      chk("halt_issued", 64'(issued_cnt), 64'd1);

      // asynchronous reset in the middle of WAIT
      do_reset();
      push_word(tbl[1].word);
      wait_enable("ar_enable0");
      reply(1'b1);
      push_word(tbl[2].word);
      wait_enable("ar_enable1");
      tick();
      #3;
      rst = 1'b1;
      #1;
      chk("ar_fields", 64'(dut_fields()), 64'd0);
      chk("ar_flags", 64'({enable, halted, fetch_ready}), 64'b001);
      chk("ar_counts", 64'({issued_cnt, stall_cnt}), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         tick();
         if (enable) seen++;
      end
      chk("ar_no_enable", 64'(seen), 64'd0);

      // randomized traffic against an in-order issue model
      do_reset();
      q.delete();
      prev_xfer = 1'b0;
      prev_word = '0;
      awaiting = 1'b0;
      retry = 1'b0;
      delay = 0;
      rej_cyc = 0;
      exp_iss = 0;
      exp_stall = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         rs_ack = 1'b0;
         rs_accept = 1'b0;
         if (prev_xfer && prev_word[31:30] != 2'b11) q.push_back(prev_word);
         if (cyc >= 600 && q.size() == 0 && !awaiting && !retry && !prev_xfer) break;
         if (enable) begin
            if (awaiting || q.size() == 0) begin
               chk("rand_unexpected_enable", 64'(q.size()), 64'hFFFF);
            end else begin
               chk("rand_fields", 64'(dut_fields()), 64'(exp_fields(q[0])));
               if (retry) chk("rand_retry_gap", 64'(cyc - rej_cyc), 64'(BACKOFF + 1));
               retry = 1'b0;
               awaiting = 1'b1;
               delay = $urandom_range(0, 2);
            end
         end else if (awaiting) begin
            if (delay == 0) begin
               acc = ($urandom_range(0, 3) != 0);
               rs_ack = 1'b1;
               rs_accept = acc;
               awaiting = 1'b0;
               if (acc) begin
                  void'(q.pop_front());
                  exp_iss++;
               end else begin
                  exp_stall++;
                  rej_cyc = cyc;
                  retry = 1'b1;
               end
            end else begin
               delay--;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            rs_ack = 1'b1;
            rs_accept = 1'($urandom_range(0, 1));
         end
         ru = 3'($urandom_range(0, 6));
         if (ru == 3'd5) ru = 3'd7;
         rw = $urandom();
         fetch_valid = (cyc < 600) && ($urandom_range(0, 1) == 1);
         fetch_instr = {ru, rw[28:0]};
         prev_xfer = fetch_valid && fetch_ready;
         prev_word = fetch_instr;
      end
      fetch_valid = 1'b0;
      rs_ack = 1'b0;
      chk("rand_drained", 64'({q.size(), awaiting, retry}), 64'd0);
      chk("rand_issued", 64'(issued_cnt), 64'(16'(exp_iss)));
      chk("rand_stall", 64'(stall_cnt), 64'(16'(exp_stall)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
